// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: sequences the PC counter, fetches one word per PC
// from instruction memory and hands it to decode over a valid/ready handshake.
module pc_fetch_ctrl #(
    parameter int           n        = 32,
    parameter logic [n-1:0] RESET_PC = '0,
    parameter int           TIMEOUT  = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run,
    input  logic [n-1:0] PCout,
    output logic         PCload,
    output logic         PCinc,
    output logic [n-1:0] PCdata,
    output logic         imem_req,
    output logic [n-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [n-1:0] imem_rdata,
    input  logic         br_valid,
    input  logic [n-1:0] br_target,
    output logic [n-1:0] instr,
    output logic [n-1:0] instr_pc,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic         fetch_err
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        IDLE  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        HOLD  = 3'd4,
        STEP  = 3'd5
    } state_t;

    state_t         state_r;
    state_t         next_s;
    logic           armed_r;
    logic [TW-1:0]  tcnt_r;
    logic           timeout_s;
    logic [n-1:0]   pcdata_r;
    logic [n-1:0]   addr_r;
    logic [n-1:0]   instr_r;
    logic [n-1:0]   instr_pc_r;
    logic           err_r;

    assign timeout_s = (tcnt_r == TW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= LOAD;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state decode; a redirect outside LOAD always wins and discards any same-cycle ack.
    always_comb begin
        next_s = state_r;
        if (br_valid && (state_r != LOAD)) begin
            next_s = LOAD;
        end else begin
            case (state_r)
                // The first LOAD cycle after reset has PCload low, so LOAD lingers one cycle.
                LOAD:    next_s = (!armed_r || br_valid) ? LOAD : (run ? ISSUE : IDLE);
                IDLE:    next_s = (run && !err_r) ? ISSUE : IDLE;
                ISSUE:   next_s = WAIT;
                WAIT:    next_s = imem_ack ? HOLD : (timeout_s ? IDLE : WAIT);
                HOLD:    next_s = instr_ready ? STEP : HOLD;
                STEP:    next_s = run ? ISSUE : IDLE;
                default: next_s = LOAD;
            endcase
        end
    end

    // Datapath registers: redirect target, request address, timeout count, fetched word, error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_r    <= 1'b0;
            pcdata_r   <= RESET_PC;
            addr_r     <= '0;
            tcnt_r     <= '0;
            instr_r    <= '0;
            instr_pc_r <= '0;
            err_r      <= 1'b0;
        end else begin
            armed_r <= 1'b1;
            if (br_valid) begin
                pcdata_r <= br_target;
            end
            if (state_r == ISSUE) begin
                addr_r <= PCout;
                tcnt_r <= '0;
            end else if ((state_r == WAIT) && !imem_ack && !timeout_s) begin
                tcnt_r <= tcnt_r + TW'(1);
            end
            if ((state_r == WAIT) && !br_valid) begin
                if (imem_ack) begin
                    instr_r    <= imem_rdata;
                    instr_pc_r <= addr_r;
                end else if (timeout_s) begin
                    err_r <= 1'b1;
                end
            end
        end
    end

    // Control outputs are decoded from state only, never from inputs.
    assign PCload      = (state_r == LOAD) && armed_r;
    assign PCinc       = (state_r == STEP);
    assign PCdata      = pcdata_r;
    assign imem_req    = (state_r == ISSUE) || (state_r == WAIT);
    assign imem_addr   = (state_r == ISSUE) ? PCout : addr_r;
    assign instr_valid = (state_r == HOLD);
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;
    assign fetch_err   = err_r;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl with a PC counter model, an imem responder
// and a scoreboard of expected instruction PCs consumed at each decode handshake.
module tb_pc_fetch_ctrl;

    localparam int          TO  = 15;
    localparam logic [31:0] RPC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n, run, PCload, PCinc, imem_req, imem_ack, br_valid;
    logic        instr_valid, instr_ready, fetch_err;
    logic [31:0] PCout, PCdata, imem_addr, imem_rdata, br_target, instr, instr_pc;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          pcinc_cnt = 0;
    int          ack_delay = 0;
    bit          ack_en = 1'b1;
    logic [31:0] sb_q[$];
    int          acc_cyc[$];
    logic [31:0] exp_pc;

    pc_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .run(run), .PCout(PCout), .PCload(PCload), .PCinc(PCinc),
        .PCdata(PCdata), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .br_valid(br_valid), .br_target(br_target), .instr(instr),
        .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'd7 + 32'h1234_5678;
    endfunction

    // PC counter model: load has priority over increment, new value one cycle later.
    initial begin
        logic        pl, pi;
        logic [31:0] pd;
        PCout = 32'h0000_0777;
        forever begin
            @(negedge clk);
            pl = PCload; pi = PCinc; pd = PCdata;
            @(posedge clk);
            #1;
            if (pl) PCout = pd;
            else if (pi) PCout = PCout + 32'd1;
        end
    end

    // Instruction memory: ack ack_delay cycles into WAIT (0 = first WAIT cycle).
    initial begin
        int rcnt;
        rcnt = 0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            imem_ack = 1'b0;
            if (imem_req) rcnt++;
            else rcnt = 0;
            if (imem_req && ack_en && (rcnt == ack_delay + 2)) begin
                imem_ack = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end
        end
    end

    // Monitor: control exclusivity every cycle, scoreboard compare at each handshake.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (PCinc) pcinc_cnt++;
            checks++;
            if (PCload && PCinc) begin
                errors++;
                $display("FAIL load_inc_overlap cycle %0d: PCload=%b PCinc=%b, required not both", cyc, PCload, PCinc);
            end
            if (instr_valid && instr_ready) begin
                acc_cyc.push_back(cyc);
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_instr: instr_pc=%h accepted, none expected", instr_pc);
                end else begin
                    exp_pc = sb_q.pop_front();
                    if (instr_pc !== exp_pc) begin
                        errors++;
                        $display("FAIL instr_pc: got %h, expected %h", instr_pc, exp_pc);
                    end
                    checks++;
                    if (instr !== mem_word(exp_pc)) begin
                        errors++;
                        $display("FAIL instr_word: got %h, expected %h", instr, mem_word(exp_pc));
                    end
                end
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d instrs outstanding, expected 0", sb_q.size());
        end
        run = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_sig(input int which, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (n < 20 && !((which == 0) ? PCload : (which == 1) ? imem_req : instr_valid)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL wait_%s: not seen within 20 cycles, expected asserted", name);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; instr_ready = 1'b0; br_valid = 1'b0; br_target = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if ({PCload, PCinc, imem_req, instr_valid, fetch_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: load/inc/req/valid/err=%b, expected 00000",
                     {PCload, PCinc, imem_req, instr_valid, fetch_err});
        end
        checks++;
        if (PCdata !== RPC) begin
            errors++;
            $display("FAIL reset_pcdata: got %h, expected %h", PCdata, RPC);
        end
        checks++;
        if ({instr, instr_pc, imem_addr} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: instr=%h instr_pc=%h addr=%h, expected 0", instr, instr_pc, imem_addr);
        end
    endtask

    task automatic test_basic();
        int p0, a0;
        p0 = pcinc_cnt;
        a0 = acc_cyc.size();
        ack_delay = 0; run = 1'b1; instr_ready = 1'b1;
        sb_q.push_back(32'd0); sb_q.push_back(32'd1); sb_q.push_back(32'd2);
        rst_n = 1'b1;
        wait_sig(0, "pcload");
        checks++;
        if (PCdata !== RPC || PCinc !== 1'b0) begin
            errors++;
            $display("FAIL basic_load: PCdata=%h PCinc=%b, expected %h 0", PCdata, PCinc, RPC);
        end
        drain();
        checks++;
        if (pcinc_cnt - p0 != 3) begin
            errors++;
            $display("FAIL basic_pcinc_count: got %0d, expected 3", pcinc_cnt - p0);
        end
        checks++;
        if (acc_cyc.size() - a0 != 3) begin
            errors++;
            $display("FAIL basic_accepts: got %0d, expected 3", acc_cyc.size() - a0);
        end else if (acc_cyc[a0+1] - acc_cyc[a0] != 4 || acc_cyc[a0+2] - acc_cyc[a0+1] != 4) begin
            errors++;
            $display("FAIL basic_throughput: spacing %0d %0d, expected 4 4",
                     acc_cyc[a0+1] - acc_cyc[a0], acc_cyc[a0+2] - acc_cyc[a0+1]);
        end
    endtask

    task automatic test_hold_stall();
        logic [31:0] ci, cp;
        instr_ready = 1'b0; run = 1'b1;
        sb_q.push_back(32'd3);
        wait_sig(2, "valid_hold");
        ci = instr; cp = instr_pc;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || instr !== ci || instr_pc !== cp || PCinc !== 1'b0 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable %0d: valid=%b instr=%h pc=%h inc=%b req=%b, expected 1 %h %h 0 0",
                         i, instr_valid, instr, instr_pc, PCinc, imem_req, ci, cp);
            end
        end
        instr_ready = 1'b1; run = 1'b0;
        @(negedge clk);
        checks++;
        if (PCinc !== 1'b1 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: PCinc=%b valid=%b, expected 1 0", PCinc, instr_valid);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle_req: got %b, expected 0", imem_req);
        end
    endtask

    task automatic test_run_stop();
        int reqs;
        instr_ready = 1'b0; run = 1'b1;
        sb_q.push_back(32'd4);
        wait_sig(2, "valid_runstop");
        run = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL runstop_hold: valid=%b, expected 1", instr_valid);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (PCinc !== 1'b1) begin
            errors++;
            $display("FAIL runstop_step: PCinc=%b, expected 1", PCinc);
        end
        reqs = 0;
        repeat (4) begin
            @(negedge clk);
            if (imem_req) reqs++;
        end
        checks++;
        if (reqs != 0) begin
            errors++;
            $display("FAIL runstop_idle: %0d req cycles, expected 0", reqs);
        end
        sb_q.push_back(32'd5);
        run = 1'b1;
        wait_sig(1, "req_restart");
        checks++;
        if (imem_addr !== 32'd5) begin
            errors++;
            $display("FAIL runstop_addr: got %h, expected %h", imem_addr, 32'd5);
        end
        drain();
    endtask

    task automatic test_redirect();
        ack_delay = 0; instr_ready = 1'b1;
        sb_q.push_back(32'h40);
        run = 1'b1;
        wait_sig(1, "req_redirect");
        @(negedge clk);
        br_valid = 1'b1; br_target = 32'h40;
        @(negedge clk);
        br_valid = 1'b0;
        checks++;
        if (PCload !== 1'b1 || PCdata !== 32'h40 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_load: load=%b data=%h req=%b valid=%b, expected 1 00000040 0 0",
                     PCload, PCdata, imem_req, instr_valid);
        end
        drain();
    endtask

    task automatic test_timeout();
        int n, reqs;
        ack_en = 1'b0; run = 1'b1;
        wait_sig(1, "req_timeout");
        n = 1;
        @(negedge clk);
        while (imem_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != TO + 1 || fetch_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout: req cycles=%0d err=%b, expected %0d 1", n, fetch_err, TO + 1);
        end
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            run = ~run;
            @(negedge clk);
            if (imem_req) reqs++;
        end
        checks++;
        if (reqs != 0 || fetch_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: req cycles=%0d err=%b, expected 0 1", reqs, fetch_err);
        end
        run = 1'b0; ack_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_clears_err: got %b, expected 0", fetch_err);
        end
        ack_delay = 3; run = 1'b1; rst_n = 1'b1;
        wait_sig(1, "req_mid");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({PCload, PCinc, imem_req, instr_valid, fetch_err} !== 5'b0 || PCdata !== RPC) begin
            errors++;
            $display("FAIL reset_async: flags=%b PCdata=%h, expected 00000 %h",
                     {PCload, PCinc, imem_req, instr_valid, fetch_err}, PCdata, RPC);
        end
        @(negedge clk);
        ack_delay = 0;
        sb_q.push_back(RPC);
        rst_n = 1'b1;
        wait_sig(0, "pcload_mid");
        checks++;
        if (PCdata !== RPC) begin
            errors++;
            $display("FAIL reset_reload: PCdata=%h, expected %h", PCdata, RPC);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_stall();
        test_run_stop();
        test_redirect();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
